// File: rtl/dma_job_arbiter.sv
// Round-robin arbiter that latches one DMA job at a time from NREQ requesters and sequences it
// through the DMA controller. Optional WAIT-state watchdog is built only with DMA_ARB_WDOG_EN.
module dma_job_arbiter #(
  parameter int unsigned NREQ       = 3,
  parameter int unsigned BIT_TRANS  = 18,
  parameter int unsigned WDOG_LIMIT = 1048575
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ-1:0]           req_dir,
  input  logic [NREQ*32-1:0]        req_base_addr,
  input  logic [NREQ*BIT_TRANS-1:0] req_num_trans,
  input  logic [NREQ*16-1:0]        req_num_blk,
  output logic [NREQ-1:0]           o_job_done,
  output logic [1:0]                o_start,
  output logic [31:0]               o_base_address_rd,
  output logic [31:0]               o_base_address_wr,
  output logic [BIT_TRANS-1:0]      o_num_trans,
  output logic [15:0]               o_max_req_blk_idx,
  input  logic                      i_rd_job_done,
  input  logic                      i_wr_job_done,
  output logic                      o_busy,
  output logic [2:0]                o_grant_id,
  input  logic                      i_err_clr,
  output logic                      o_err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [2:0]           last_grant_q, last_grant_d;
  logic [2:0]           grant_q, grant_d;
  logic                 dir_q, dir_d;
  logic [31:0]          addr_rd_q, addr_rd_d;
  logic [31:0]          addr_wr_q, addr_wr_d;
  logic [BIT_TRANS-1:0] num_trans_q, num_trans_d;
  logic [15:0]          num_blk_q, num_blk_d;
  logic [NREQ-1:0]      req_ready_q, req_ready_d;
  logic [NREQ-1:0]      job_done_q, job_done_d;
  logic [1:0]           start_q, start_d;
  logic                 busy_q, busy_d;

  logic                 pick_found;
  logic [2:0]           pick_idx;
  logic                 sel_dir;
  logic [31:0]          sel_addr;
  logic [BIT_TRANS-1:0] sel_num_trans;
  logic [15:0]          sel_num_blk;

  // Search order starts one past the last completed grant, wrapping at NREQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        if (!pick_found && req_valid[k] &&
            k == (32'(last_grant_q) + i + 1) % NREQ) begin
          pick_found = 1'b1;
          pick_idx   = 3'(k);
        end
      end
    end
  end

  always_comb begin
    sel_dir       = 1'b0;
    sel_addr      = '0;
    sel_num_trans = '0;
    sel_num_blk   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (pick_idx == 3'(k)) begin
        sel_dir       = req_dir[k];
        sel_addr      = req_base_addr[32*k +: 32];
        sel_num_trans = req_num_trans[BIT_TRANS*k +: BIT_TRANS];
        sel_num_blk   = req_num_blk[16*k +: 16];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    dir_d        = dir_q;
    addr_rd_d    = addr_rd_q;
    addr_wr_d    = addr_wr_q;
    num_trans_d  = num_trans_q;
    num_blk_d    = num_blk_q;
    req_ready_d  = '0;
    job_done_d   = '0;
    start_d      = 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d     = ST_LAUNCH;
          req_ready_d = NREQ'(1'b1) << pick_idx;
          grant_d     = pick_idx;
          dir_d       = sel_dir;
          num_trans_d = sel_num_trans;
          num_blk_d   = sel_num_blk;
          if (sel_dir) addr_wr_d = sel_addr;
          else         addr_rd_d = sel_addr;
        end
      end
      ST_LAUNCH: begin
        if (num_blk_q == '0) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_WAIT;
          start_d = {1'b1, dir_q};
        end
      end
      ST_WAIT: begin
        if (dir_q ? i_wr_job_done : i_rd_job_done) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d      = ST_IDLE;
        job_done_d   = NREQ'(1'b1) << grant_q;
        last_grant_d = grant_q;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 3'(NREQ - 1);
      grant_q      <= '0;
      dir_q        <= 1'b0;
      addr_rd_q    <= '0;
      addr_wr_q    <= '0;
      num_trans_q  <= '0;
      num_blk_q    <= '0;
      req_ready_q  <= '0;
      job_done_q   <= '0;
      start_q      <= 2'b00;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      dir_q        <= dir_d;
      addr_rd_q    <= addr_rd_d;
      addr_wr_q    <= addr_wr_d;
      num_trans_q  <= num_trans_d;
      num_blk_q    <= num_blk_d;
      req_ready_q  <= req_ready_d;
      job_done_q   <= job_done_d;
      start_q      <= start_d;
      busy_q       <= busy_d;
    end
  end

  assign req_ready         = req_ready_q;
  assign o_job_done        = job_done_q;
  assign o_start           = start_q;
  assign o_base_address_rd = addr_rd_q;
  assign o_base_address_wr = addr_wr_q;
  assign o_num_trans       = num_trans_q;
  assign o_max_req_blk_idx = num_blk_q;
  assign o_busy            = busy_q;
  assign o_grant_id        = grant_q;

`ifdef DMA_ARB_WDOG_EN
  localparam int unsigned WDW = (WDOG_LIMIT < 2) ? 1 : $clog2(WDOG_LIMIT + 1);

  logic [WDW-1:0] wdog_cnt_q, wdog_cnt_d;
  logic           err_q, err_d;

  // Counter saturates at the limit so the error fires once per WAIT visit and a clear sticks.
  always_comb begin
    wdog_cnt_d = wdog_cnt_q;
    err_d      = err_q;
    if (state_q == ST_LAUNCH) begin
      wdog_cnt_d = '0;
    end else if (state_q == ST_WAIT && wdog_cnt_q != WDW'(WDOG_LIMIT)) begin
      wdog_cnt_d = wdog_cnt_q + 1'b1;
    end
    if (i_err_clr) err_d = 1'b0;
    if (state_q == ST_WAIT && wdog_cnt_q != WDW'(WDOG_LIMIT) &&
        wdog_cnt_d == WDW'(WDOG_LIMIT)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wdog_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      err_q      <= err_d;
    end
  end

  assign o_err = err_q;
`else
  logic unused_wdog;
  assign unused_wdog = i_err_clr & (WDOG_LIMIT != 0);
  assign o_err       = 1'b0;
`endif

endmodule
